// File: rtl/dice_pkg.sv
// Shared definitions for the dice game-control slice: hand codes, hand
// bonuses, legal die range and the game FSM state encoding.
package dice_pkg;

  // Hand codes, ordered so that a larger code is a stronger hand
  localparam logic [2:0] HAND_NONE       = 3'd0;
  localparam logic [2:0] HAND_PAIR       = 3'd1;
  localparam logic [2:0] HAND_TWO_PAIR   = 3'd2;
  localparam logic [2:0] HAND_THREE_KIND = 3'd3;
  localparam logic [2:0] HAND_STRAIGHT   = 3'd4;
  localparam logic [2:0] HAND_FOUR_KIND  = 3'd5;

  // Bonus points added on top of the die sum for each hand
  localparam logic [5:0] BONUS_NONE       = 6'd0;
  localparam logic [5:0] BONUS_PAIR       = 6'd2;
  localparam logic [5:0] BONUS_TWO_PAIR   = 6'd5;
  localparam logic [5:0] BONUS_THREE_KIND = 6'd8;
  localparam logic [5:0] BONUS_STRAIGHT   = 6'd10;
  localparam logic [5:0] BONUS_FOUR_KIND  = 6'd20;

  // Legal face values coming out of the generator
  localparam logic [3:0] DIE_MIN = 4'd1;
  localparam logic [3:0] DIE_MAX = 4'd6;

  // Game FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROLL   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  // True when a die shows a face the generator is allowed to produce
  function automatic logic dieValid(input logic [3:0] die);
    return (die >= DIE_MIN) && (die <= DIE_MAX);
  endfunction

endpackage

// File: rtl/dice_hand_classify.sv
// Purely combinational hand classifier: counts how often each face occurs,
// looks for straights, and produces the hand code, score and an invalid flag.
module dice_hand_classify
  import dice_pkg::*;
(
  input  logic [3:0] i_die1,
  input  logic [3:0] i_die2,
  input  logic [3:0] i_die3,
  input  logic [3:0] i_die4,
  output logic [2:0] o_hand,
  output logic [5:0] o_score,
  output logic       o_invalid
);

  logic [3:0] w_dice [4];
  logic [2:0] w_faceCount [1:6];
  logic [6:1] w_faceSeen;
  logic [2:0] w_pairCount;
  logic       w_hasFour;
  logic       w_hasThree;
  logic       w_straight;
  logic [5:0] w_sum;
  logic [5:0] w_bonus;

  assign w_dice[0] = i_die1;
  assign w_dice[1] = i_die2;
  assign w_dice[2] = i_die3;
  assign w_dice[3] = i_die4;

  // Any die outside the legal face range poisons the whole hand
  always_comb begin
    o_invalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!dieValid(w_dice[i])) o_invalid = 1'b1;
    end
  end

  // Occurrence count of each legal face across the four dice
  always_comb begin
    for (int f = 1; f <= 6; f++) begin
      w_faceCount[f] = 3'd0;
      for (int i = 0; i < 4; i++) begin
        if (w_dice[i] == 4'(f)) w_faceCount[f] = w_faceCount[f] + 3'd1;
      end
    end
  end

  // Reduce the face counts to the few facts the hand ranking needs
  always_comb begin
    w_hasFour   = 1'b0;
    w_hasThree  = 1'b0;
    w_pairCount = 3'd0;
    w_faceSeen  = '0;
    for (int f = 1; f <= 6; f++) begin
      if (w_faceCount[f] == 3'd4) w_hasFour = 1'b1;
      if (w_faceCount[f] == 3'd3) w_hasThree = 1'b1;
      if (w_faceCount[f] == 3'd2) w_pairCount = w_pairCount + 3'd1;
      w_faceSeen[f] = (w_faceCount[f] != 3'd0);
    end
    // With only four dice, four distinct consecutive faces seen is a straight
    w_straight = (&w_faceSeen[4:1]) | (&w_faceSeen[5:2]) | (&w_faceSeen[6:3]);
  end

  // Sum of pips; six bits so even illegal faces cannot wrap before being discarded
  always_comb begin
    w_sum = {2'b00, i_die1} + {2'b00, i_die2} + {2'b00, i_die3} + {2'b00, i_die4};
  end

  // Priority ranking of the hand and final score, forced to zero on bad dice
  always_comb begin
    o_hand  = HAND_NONE;
    w_bonus = BONUS_NONE;
    if (w_hasFour) begin
      o_hand  = HAND_FOUR_KIND;
      w_bonus = BONUS_FOUR_KIND;
    end else if (w_straight) begin
      o_hand  = HAND_STRAIGHT;
      w_bonus = BONUS_STRAIGHT;
    end else if (w_hasThree) begin
      o_hand  = HAND_THREE_KIND;
      w_bonus = BONUS_THREE_KIND;
    end else if (w_pairCount == 3'd2) begin
      o_hand  = HAND_TWO_PAIR;
      w_bonus = BONUS_TWO_PAIR;
    end else if (w_pairCount == 3'd1) begin
      o_hand  = HAND_PAIR;
      w_bonus = BONUS_PAIR;
    end
    o_score = w_sum + w_bonus;
    if (o_invalid) begin
      o_hand  = HAND_NONE;
      o_score = 6'd0;
    end
  end

endmodule

// File: rtl/dice_score_fsm.sv
// Game-control stage behind the four-dice generator: turns a button press
// into a roll_trigger burst, captures and scores the dice, and keeps the
// running total and roll count for the display logic.
// Optional feature macro: DICE_SCORE_BEST_EN (best single-roll score register).
module dice_score_fsm
  import dice_pkg::*;
#(
  parameter int SPIN_CYCLES = 16,
  parameter int MAX_ROLLS   = 10,
  parameter int TOTAL_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_roll_btn,
  input  logic               i_new_game,
  input  logic [3:0]         i_die1,
  input  logic [3:0]         i_die2,
  input  logic [3:0]         i_die3,
  input  logic [3:0]         i_die4,
  output logic               o_roll_trigger,
  output logic [3:0]         o_held1,
  output logic [3:0]         o_held2,
  output logic [3:0]         o_held3,
  output logic [3:0]         o_held4,
  output logic [2:0]         o_hand,
  output logic [5:0]         o_score,
  output logic [TOTAL_W-1:0] o_total,
  output logic [3:0]         o_roll_count,
  output logic               o_result_valid,
  output logic               o_game_over,
  output logic               o_dice_err,
  output logic [5:0]         o_best_score
);

  localparam logic [7:0] SPIN_LOAD   = 8'(SPIN_CYCLES - 1);
  localparam logic [3:0] ROLL_LIMIT  = 4'(MAX_ROLLS);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_btnQ;
  logic               w_rise;
  logic [7:0]         r_spinCnt;
  logic [3:0]         r_held1, r_held2, r_held3, r_held4;
  logic [2:0]         r_hand;
  logic [5:0]         r_score;
  logic [TOTAL_W-1:0] r_total;
  logic [3:0]         r_rollCount;
  logic               r_resultValid;
  logic               r_diceErr;
  logic [2:0]         w_hand;
  logic [5:0]         w_score;
  logic               w_invalid;
  logic [TOTAL_W:0]   w_totalSum;
  logic [TOTAL_W-1:0] w_totalNext;
  logic [3:0]         w_countNext;

  // Presses only count in IDLE, and a simultaneous new_game swallows them
  assign w_rise = i_roll_btn && !r_btnQ && (r_state == ST_IDLE) && !i_new_game;

  assign w_totalSum  = {1'b0, r_total} + (TOTAL_W + 1)'(r_score);
  assign w_totalNext = w_totalSum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_totalSum[TOTAL_W-1:0];
  assign w_countNext = r_rollCount + 4'd1;

  dice_hand_classify u_classify (
    .i_die1    (r_held1),
    .i_die2    (r_held2),
    .i_die3    (r_held3),
    .i_die4    (r_held4),
    .o_hand    (w_hand),
    .o_score   (w_score),
    .o_invalid (w_invalid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic; new_game pulls every state back to IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_rise) w_nextState = ST_ROLL;
      ST_ROLL:   if (r_spinCnt == 8'd0) w_nextState = ST_SETTLE;
      ST_SETTLE: w_nextState = ST_EVAL;
      ST_EVAL:   w_nextState = ST_UPDATE;
      ST_UPDATE: w_nextState = (w_countNext == ROLL_LIMIT) ? ST_OVER : ST_IDLE;
      ST_OVER:   w_nextState = ST_OVER;
      default:   w_nextState = ST_IDLE;
    endcase
    if (i_new_game) w_nextState = ST_IDLE;
  end

  // Moore outputs decoded straight from the state
  always_comb begin
    o_roll_trigger = 1'b0;
    o_game_over    = 1'b0;
    case (r_state)
      ST_ROLL: o_roll_trigger = 1'b1;
      ST_OVER: o_game_over    = 1'b1;
      default: ;
    endcase
  end

  // Previous button level, kept every cycle so a held button never re-fires
  always_ff @(posedge clk) begin
    if (rst) r_btnQ <= 1'b0;
    else     r_btnQ <= i_roll_btn;
  end

  // Spin length counter, loaded on the accepted press and run down in ROLL
  always_ff @(posedge clk) begin
    if (rst || i_new_game) begin
      r_spinCnt <= 8'd0;
    end else if (w_rise) begin
      r_spinCnt <= SPIN_LOAD;
    end else if (r_state == ST_ROLL && r_spinCnt != 8'd0) begin
      r_spinCnt <= r_spinCnt - 8'd1;
    end
  end

  // Roll datapath: capture dice, latch classification, accumulate the game
  always_ff @(posedge clk) begin
    if (rst || i_new_game) begin
      r_held1       <= 4'd0;
      r_held2       <= 4'd0;
      r_held3       <= 4'd0;
      r_held4       <= 4'd0;
      r_hand        <= HAND_NONE;
      r_score       <= 6'd0;
      r_total       <= '0;
      r_rollCount   <= 4'd0;
      r_resultValid <= 1'b0;
      r_diceErr     <= 1'b0;
    end else begin
      r_resultValid <= (r_state == ST_UPDATE);
      case (r_state)
        ST_SETTLE: begin
          r_held1 <= i_die1;
          r_held2 <= i_die2;
          r_held3 <= i_die3;
          r_held4 <= i_die4;
        end
        ST_EVAL: begin
          r_hand    <= w_hand;
          r_score   <= w_score;
          r_diceErr <= r_diceErr | w_invalid;
        end
        ST_UPDATE: begin
          r_total     <= w_totalNext;
          r_rollCount <= w_countNext;
        end
        default: ;
      endcase
    end
  end

`ifdef DICE_SCORE_BEST_EN
  logic [5:0] r_best;

  // Best single-roll score; survives new_game, only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best <= 6'd0;
    end else if (r_state == ST_UPDATE && !i_new_game && r_score > r_best) begin
      r_best <= r_score;
    end
  end

  assign o_best_score = r_best;
`else
  assign o_best_score = 6'd0;
`endif

  assign o_held1        = r_held1;
  assign o_held2        = r_held2;
  assign o_held3        = r_held3;
  assign o_held4        = r_held4;
  assign o_hand         = r_hand;
  assign o_score        = r_score;
  assign o_total        = r_total;
  assign o_roll_count   = r_rollCount;
  assign o_result_valid = r_resultValid;
  assign o_dice_err     = r_diceErr;

endmodule
